// File: rtl/coefficient_decoder_pkg.sv
// Shared constants and FSM encoding for the entropy-to-coefficient stage.
package coefficient_decoder_pkg;

    localparam int         COEF_W_DEF = 8;
    localparam int         BLOCK_SIZE = 64;
    localparam logic [7:0] SYM_EOB    = 8'h00;
    localparam logic [7:0] SYM_ZRL    = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AMP,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/coefficient_decoder_if.sv
// Symbol/bit handshakes and the coefficient beat towards the table stage.
interface coefficient_decoder_if #(
    parameter int COEF_W = coefficient_decoder_pkg::COEF_W_DEF
);
    logic [7:0]              sym;
    logic                    sym_valid;
    logic                    sym_ready;
    logic                    bit_in;
    logic                    bit_valid;
    logic                    bit_ready;
    logic [3:0]              r_value;
    logic signed [COEF_W-1:0] coefficient;
    logic                    is_new_coefficient;
    logic                    is_dc;
    logic                    block_done;
    logic                    err;

    modport master (
        output sym, sym_valid, bit_in, bit_valid,
        input  sym_ready, bit_ready, r_value, coefficient,
               is_new_coefficient, is_dc, block_done, err
    );

    modport slave (
        input  sym, sym_valid, bit_in, bit_valid,
        output sym_ready, bit_ready, r_value, coefficient,
               is_new_coefficient, is_dc, block_done, err
    );
endinterface

// File: rtl/coefficient_decoder_amplitude_extend.sv
// Combinational JPEG amplitude extension; categories past COEF_W-1 saturate by sign.
module amplitude_extend #(
    parameter int COEF_W = coefficient_decoder_pkg::COEF_W_DEF
) (
    input  logic [COEF_W-2:0]        bits_i,
    input  logic [3:0]               cat_i,
    input  logic                     msb_i,
    output logic signed [COEF_W-1:0] coef_o,
    output logic                     ovf_o
);
    localparam int MAX_CAT = COEF_W - 1;

    logic [COEF_W-1:0] mask;
    logic [COEF_W-1:0] val;

    always_comb begin
        mask  = (COEF_W'(1) << cat_i) - COEF_W'(1);
        val   = {1'b0, bits_i} & mask;
        ovf_o = int'(cat_i) > MAX_CAT;
        if (cat_i == '0)
            coef_o = '0;
        else if (ovf_o)
            coef_o = msb_i ? {1'b0, {(COEF_W-1){1'b1}}} : {1'b1, {(COEF_W-1){1'b0}}};
        else if (msb_i)
            coef_o = val;
        else
            coef_o = val - mask;  // leading 0 marks a negative amplitude
    end
endmodule

// File: rtl/coefficient_decoder.sv
// Turns RRRRSSSS symbols plus serial amplitude bits into (run, coefficient) beats,
// tracking block position in step with the downstream table stage.
module coefficient_decoder
    import coefficient_decoder_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    coefficient_decoder_if.slave  dec_if
);
    localparam int MAX_CAT = COEF_W - 1;

    state_t                   state_q, state_d;
    logic [3:0]               run_q, run_d, cat_q, cat_d, cnt_q, cnt_d;
    logic                     dc_q, dc_d, msb_q, msb_d;
    logic [MAX_CAT-2:0]       sh_q, sh_d;
    logic [6:0]               pos_q, pos_d;
    logic [3:0]               rv_q, rv_d;
    logic signed [COEF_W-1:0] coef_q, coef_d;
    logic                     stb_q, stb_d, isdc_q, isdc_d, done_q, done_d, err_q, err_d;

    // S==0 symbols finish straight from the port (IDLE->EMIT); others from latched state.
    logic                     in_idle, cur_dc, amp_msb, amp_ovf, go;
    logic [3:0]               cur_run, cur_cat;
    logic [MAX_CAT-1:0]       amp_bits;
    logic signed [COEF_W-1:0] amp_coef;

    assign in_idle  = state_q == ST_IDLE;
    assign cur_run  = in_idle ? dec_if.sym[7:4] : run_q;
    assign cur_cat  = in_idle ? dec_if.sym[3:0] : cat_q;
    assign cur_dc   = in_idle ? (pos_q == '0) : dc_q;
    assign amp_bits = {sh_q, dec_if.bit_in};
    assign amp_msb  = (cnt_q == '0) ? dec_if.bit_in : msb_q;

    amplitude_extend #(.COEF_W(COEF_W)) u_amp (
        .bits_i (amp_bits),
        .cat_i  (cur_cat),
        .msb_i  (amp_msb),
        .coef_o (amp_coef),
        .ovf_o  (amp_ovf)
    );

    logic [3:0]               e_run;
    logic signed [COEF_W-1:0] e_coef;
    logic                     e_done, e_err;
    logic [6:0]               pos_sum, pos_nxt;

    always_comb begin
        e_run   = '0;
        e_coef  = amp_coef;
        e_done  = 1'b0;
        e_err   = amp_ovf;
        pos_sum = pos_q + {3'b000, cur_run};
        pos_nxt = pos_sum + 7'd1;
        if (cur_dc) begin
            pos_nxt = 7'd1;
        end else if ({cur_run, cur_cat} == SYM_EOB) begin
            pos_nxt = '0;
            e_done  = 1'b1;
        end else begin
            if (cur_cat == '0 && {cur_run, cur_cat} != SYM_ZRL)
                e_err = 1'b1;
            // A run past the last index is clamped so the table stage still closes the block.
            if (pos_sum > 7'(BLOCK_SIZE - 1)) begin
                e_err   = 1'b1;
                e_run   = 4'(7'(BLOCK_SIZE - 1) - pos_q);
                pos_nxt = '0;
                e_done  = 1'b1;
            end else begin
                e_run = cur_run;
                if (pos_nxt == 7'(BLOCK_SIZE)) begin
                    pos_nxt = '0;
                    e_done  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cat_d   = cat_q;
        dc_d    = dc_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        msb_d   = msb_q;
        pos_d   = pos_q;
        rv_d    = '0;
        coef_d  = '0;
        stb_d   = 1'b0;
        isdc_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        go      = 1'b0;
        unique case (state_q)
            ST_IDLE: if (dec_if.sym_valid) begin
                run_d = dec_if.sym[7:4];
                cat_d = dec_if.sym[3:0];
                dc_d  = cur_dc;
                cnt_d = '0;
                if (dec_if.sym[3:0] == '0) go = 1'b1;
                else                       state_d = ST_AMP;
            end
            ST_AMP: if (dec_if.bit_valid) begin
                sh_d  = {sh_q[MAX_CAT-3:0], dec_if.bit_in};
                cnt_d = cnt_q + 4'd1;
                msb_d = amp_msb;
                if (cnt_q + 4'd1 == cat_q) go = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (go) begin
            state_d = ST_EMIT;
            rv_d    = e_run;
            coef_d  = e_coef;
            stb_d   = 1'b1;
            isdc_d  = cur_dc;
            done_d  = e_done;
            err_d   = e_err;
            pos_d   = pos_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
            cat_q   <= '0;
            dc_q    <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            msb_q   <= 1'b0;
            pos_q   <= '0;
            rv_q    <= '0;
            coef_q  <= '0;
            stb_q   <= 1'b0;
            isdc_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cat_q   <= cat_d;
            dc_q    <= dc_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            msb_q   <= msb_d;
            pos_q   <= pos_d;
            rv_q    <= rv_d;
            coef_q  <= coef_d;
            stb_q   <= stb_d;
            isdc_q  <= isdc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dec_if.sym_ready          = in_idle && !rst;
    assign dec_if.bit_ready          = (state_q == ST_AMP) && !rst;
    assign dec_if.r_value            = rv_q;
    assign dec_if.coefficient        = coef_q;
    assign dec_if.is_new_coefficient = stb_q;
    assign dec_if.is_dc              = isdc_q;
    assign dec_if.block_done         = done_q;
    assign dec_if.err                = err_q;
endmodule

// File: tb/tb_coefficient_decoder.sv
// Bench for coefficient_decoder: directed vector table, reset corner, random legal streams.
module tb_coefficient_decoder;
    localparam int CW = 8;

    typedef struct packed {
        logic          stb;
        logic [3:0]    r;
        logic [CW-1:0] coef;
        logic          dc;
        logic          done;
        logic          err;
    } beat_t;

    typedef struct {
        logic [7:0]  sym;
        logic [15:0] bits;
        beat_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coefficient_decoder_if #(.COEF_W(CW)) dif ();
    coefficient_decoder #(.COEF_W(CW)) dut (.clk(clk), .rst(rst), .dec_if(dif));

    int   checks = 0, errors = 0;
    int   n_strobes = 0, exp_strobes = 0, n_both = 0;
    vec_t tbl[$];

    always @(negedge clk) begin
        if (dif.is_new_coefficient === 1'b1) n_strobes++;
        if (dif.sym_ready === 1'b1 && dif.bit_ready === 1'b1) n_both++;
    end

    function automatic beat_t mk(input int r, input int c, input bit dc, input bit done, input bit err);
        beat_t b;
        b.stb = 1'b1; b.r = 4'(r); b.coef = CW'(c); b.dc = dc; b.done = done; b.err = err;
        return b;
    endfunction

    function automatic void add(input logic [7:0] s, input logic [15:0] b, input beat_t e);
        vec_t v;
        v.sym = s; v.bits = b; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic beat_t cur_beat();
        beat_t a;
        a.stb = dif.is_new_coefficient; a.r = dif.r_value; a.coef = dif.coefficient;
        a.dc = dif.is_dc; a.done = dif.block_done; a.err = dif.err;
        return a;
    endfunction

    task automatic check_beat(input string name, input beat_t e);
        beat_t a;
        a = cur_beat();
        checks++;
        exp_strobes++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got stb=%0b r=%0d coef=%0d dc=%0b done=%0b err=%0b, expected stb=%0b r=%0d coef=%0d dc=%0b done=%0b err=%0b",
                     name, a.stb, a.r, $signed(a.coef), a.dc, a.done, a.err,
                     e.stb, e.r, $signed(e.coef), e.dc, e.done, e.err);
        end
    endtask

    task automatic check_quiet(input string name);
        logic [2:0] a;
        a = {dif.is_new_coefficient, dif.block_done, dif.err};
        checks++;
        if (a !== 3'b000) begin
            errors++;
            $display("FAIL %s: got stb/done/err=%b, expected 000", name, a);
        end
    endtask

    task automatic send_sym(input logic [7:0] s, input bit junk);
        int n;
        n = 0;
        dif.sym = s;
        dif.sym_valid = 1'b1;
        if (junk) begin
            dif.bit_valid = 1'b1;
            dif.bit_in = 1'($urandom);
        end
        while (dif.sym_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL sym_timeout: sym_ready=%b after 50 cycles, expected 1", dif.sym_ready);
        end
        @(negedge clk);
        dif.sym_valid = 1'b0;
        dif.bit_valid = 1'b0;
        dif.sym = 8'($urandom);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int nb, input int maxgap);
        int n;
        for (int i = nb - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            dif.bit_in = bits[i];
            dif.bit_valid = 1'b1;
            n = 0;
            while (dif.bit_ready !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++; errors++;
                $display("FAIL bit_timeout: bit_ready=%b after 50 cycles, expected 1", dif.bit_ready);
            end
            @(negedge clk);
            dif.bit_valid = 1'b0;
            dif.bit_in = 1'($urandom);
        end
    endtask

    // The beat must be visible exactly one cycle after the last transfer.
    task automatic run_sym(input string name, input logic [7:0] s, input logic [15:0] bits,
                           input beat_t e, input int maxgap, input bit junk);
        send_sym(s, junk);
        if (s[3:0] != 4'd0) begin
            check_quiet({name, "_amp"});
            send_bits(bits, int'(s[3:0]), maxgap);
        end
        check_beat(name, e);
    endtask

    initial begin
        logic [CW+13:0] outs;
        int mpos;

        add(8'h03, 16'b101,        mk(0,    5, 1, 0, 0));
        add(8'h00, 16'h0,          mk(0,    0, 0, 1, 0));
        add(8'h03, 16'b010,        mk(0,   -5, 1, 0, 0));
        add(8'h21, 16'b0,          mk(2,   -1, 0, 0, 0));
        add(8'h12, 16'b11,         mk(1,    3, 0, 0, 0));
        add(8'h00, 16'h0,          mk(0,    0, 0, 1, 0));
        add(8'h01, 16'b1,          mk(0,    1, 1, 0, 0));
        add(8'hF0, 16'h0,          mk(15,   0, 0, 0, 0));
        add(8'hF0, 16'h0,          mk(15,   0, 0, 0, 0));
        add(8'hF0, 16'h0,          mk(15,   0, 0, 0, 0));
        add(8'hE1, 16'b1,          mk(14,   1, 0, 1, 0));
        add(8'h00, 16'h0,          mk(0,    0, 1, 0, 0));
        add(8'hF0, 16'h0,          mk(15,   0, 0, 0, 0));
        add(8'hF0, 16'h0,          mk(15,   0, 0, 0, 0));
        add(8'hF0, 16'h0,          mk(15,   0, 0, 0, 0));
        add(8'hF1, 16'b1,          mk(14,   1, 0, 1, 1));
        add(8'h09, 16'b100000000,  mk(0,  127, 1, 0, 1));
        add(8'h26, 16'b000000,     mk(2,  -63, 0, 0, 0));
        add(8'h07, 16'b0000000,    mk(0, -127, 0, 0, 0));
        add(8'h0A, 16'h0,          mk(0, -128, 0, 0, 1));
        add(8'h50, 16'h0,          mk(5,    0, 0, 0, 1));
        add(8'h00, 16'h0,          mk(0,    0, 0, 1, 0));
        add(8'h07, 16'b1000000,    mk(0,   64, 1, 0, 0));

        dif.sym = 8'h00; dif.sym_valid = 1'b0; dif.bit_in = 1'b0; dif.bit_valid = 1'b0;
        repeat (3) @(negedge clk);
        outs = {dif.sym_ready, dif.bit_ready, dif.r_value, dif.coefficient,
                dif.is_new_coefficient, dif.is_dc, dif.block_done, dif.err};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({dif.sym_ready, dif.bit_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ready_after_reset: got sym_ready/bit_ready=%b%b, expected 10", dif.sym_ready, dif.bit_ready);
        end

        foreach (tbl[i])
            run_sym($sformatf("vec%0d", i), tbl[i].sym, tbl[i].bits, tbl[i].exp, i % 3, i[0]);

        // Reset in the middle of an AC amplitude: nothing emitted, block restarts.
        send_sym(8'h05, 1'b0);
        send_bits(16'b10, 2, 0);
        rst = 1'b1;
        @(negedge clk);
        outs = {dif.sym_ready, dif.bit_ready, dif.r_value, dif.coefficient,
                dif.is_new_coefficient, dif.is_dc, dif.block_done, dif.err};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h, expected 0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({dif.sym_ready, dif.bit_ready} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_ready: got sym_ready/bit_ready=%b%b, expected 10", dif.sym_ready, dif.bit_ready);
        end
        run_sym("midreset_dc", 8'h12, 16'b11, mk(0, 3, 1, 0, 0), 1, 0);
        run_sym("midreset_eob", 8'h00, 16'h0, mk(0, 0, 0, 1, 0), 0, 0);

        // Random legal streams against a position/amplitude model.
        mpos = 0;
        for (int t = 0; t < 300; t++) begin
            int r, cat, c, k, lim;
            logic [15:0] b;
            beat_t e;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (mpos == 0) begin
                r = $urandom_range(0, 15);
                cat = $urandom_range(0, 7);
            end else begin
                k = $urandom_range(0, 9);
                lim = (63 - mpos < 15) ? 63 - mpos : 15;
                if (k == 0) begin
                    r = 0; cat = 0;
                end else if (k == 1 && mpos + 15 <= 63) begin
                    r = 15; cat = 0;
                end else begin
                    r = $urandom_range(0, lim);
                    cat = $urandom_range(1, 7);
                end
            end
            b = 16'($urandom) & 16'((1 << cat) - 1);
            if (cat == 0)                        c = 0;
            else if (int'(b) >= (1 << (cat - 1))) c = int'(b);
            else                                 c = int'(b) - ((1 << cat) - 1);
            if (mpos == 0) begin
                e = mk(0, c, 1, 0, 0);
                mpos = 1;
            end else if (r == 0 && cat == 0) begin
                e = mk(0, 0, 0, 1, 0);
                mpos = 0;
            end else begin
                e = mk(r, c, 0, 0, 0);
                mpos = mpos + r + 1;
                if (mpos == 64) begin
                    e.done = 1'b1;
                    mpos = 0;
                end
            end
            run_sym($sformatf("rand%0d", t), {4'(r), 4'(cat)}, b, e, 3, 1'b1);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (n_strobes != exp_strobes) begin
            errors++;
            $display("FAIL strobe_count: got %0d strobes, expected %0d", n_strobes, exp_strobes);
        end
        checks++;
        if (n_both != 0) begin
            errors++;
            $display("FAIL ready_exclusive: got %0d cycles with both readies high, expected 0", n_both);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
